// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope generator.
// State encoding is visible on the env_state port, so the values are fixed.
package adsr_pkg;
   localparam int ADSR_BIT_DEPTH = 24;
   localparam logic [23:0] ENV_MAX = 24'hFFFFFF;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;
endpackage

// File: rtl/env_mul.sv
// Unsigned W x W multiplier returning the upper W bits of the product (floor).
// Shared by all envelope segments; purely combinational.
module env_mul #(
   parameter int W = 24
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] p_hi
);
   assign p_hi = W'(({{W{1'b0}}, a} * {{W{1'b0}}, b}) >> W);
endmodule

// File: rtl/adsr_env_gen.sv
// Per-voice ADSR envelope generator with exponential segments, stepped once per
// audio sample strobe. One shared multiplier serves whichever segment is active.
module adsr_env_gen
   import adsr_pkg::*;
#(
   parameter int BIT_DEPTH  = ADSR_BIT_DEPTH,
   parameter int END_THRESH = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sample_tick,
   input  logic                 gate,
   input  logic                 retrigger,
   input  logic [BIT_DEPTH-1:0] attack_base,
   input  logic [BIT_DEPTH-1:0] attack_coef,
   input  logic [BIT_DEPTH-1:0] decay_coef,
   input  logic [BIT_DEPTH-1:0] sustain_level,
   input  logic [BIT_DEPTH-1:0] release_coef,
   output logic [BIT_DEPTH-1:0] envelope,
   output logic [2:0]           env_state,
   output logic                 idle
);
   localparam logic [BIT_DEPTH-1:0] MAX_LVL = {BIT_DEPTH{1'b1}};
   localparam logic [BIT_DEPTH-1:0] THRESH  = BIT_DEPTH'(END_THRESH);

   env_state_t           state_q, state_d;
   logic [BIT_DEPTH-1:0] env_q, env_d;
   logic                 trig_q, trig_d;
   logic                 retrig_eff;
   logic [BIT_DEPTH-1:0] mul_a, mul_b, mul_hi, dec_diff;
   logic [BIT_DEPTH:0]   att_sum;
   logic                 att_full;

   function automatic logic [BIT_DEPTH-1:0] sat_env(input logic [BIT_DEPTH:0] n);
      return (n >= {1'b0, MAX_LVL}) ? MAX_LVL : n[BIT_DEPTH-1:0];
   endfunction

   env_mul #(.W(BIT_DEPTH)) u_mul (
      .a    (mul_a),
      .b    (mul_b),
      .p_hi (mul_hi)
   );

   always_comb begin
      dec_diff = env_q - sustain_level;
      mul_a    = env_q;
      mul_b    = attack_coef;
      case (state_q)
         DECAY: begin
            mul_a = dec_diff;
            mul_b = decay_coef;
         end
         RELEASE: mul_b = release_coef;
         default: ;
      endcase
      att_sum  = {1'b0, attack_base} + {1'b0, mul_hi};
      att_full = (att_sum >= {1'b0, MAX_LVL});
   end

   // A pulse arriving with the tick counts for that tick; every tick clears the latch.
   always_comb begin
      state_d    = state_q;
      env_d      = env_q;
      retrig_eff = trig_q | retrigger;
      trig_d     = retrig_eff;
      if (sample_tick) begin
         trig_d = 1'b0;
         if (!gate && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
            state_d = RELEASE;
         end else if (gate && (state_q inside {IDLE, RELEASE})) begin
            state_d = ATTACK;
         end else if (gate && retrig_eff && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
            state_d = ATTACK;
         end else begin
            case (state_q)
               IDLE: env_d = '0;
               ATTACK: begin
                  env_d = sat_env(att_sum);
                  if (att_full) state_d = DECAY;
               end
               DECAY: begin
                  if ((env_q <= sustain_level) || (mul_hi < THRESH)) begin
                     env_d   = sustain_level;
                     state_d = SUSTAIN;
                  end else begin
                     env_d = sustain_level + mul_hi;
                  end
               end
               SUSTAIN: env_d = sustain_level;
               RELEASE: begin
                  if (mul_hi < THRESH) begin
                     env_d   = '0;
                     state_d = IDLE;
                  end else begin
                     env_d = mul_hi;
                  end
               end
               default: begin
                  env_d   = '0;
                  state_d = IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         env_q   <= '0;
         trig_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         env_q   <= env_d;
         trig_q  <= trig_d;
      end
   end

   assign envelope  = env_q;
   assign env_state = state_q;
   assign idle      = (state_q == IDLE);
endmodule

// File: tb/tb_adsr_env_gen.sv
// Directed bench for adsr_env_gen: table-driven release sweep plus hand-written
// sequences for attack, decay, legato, retrigger and asynchronous reset.
module tb_adsr_env_gen;
   import adsr_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, sample_tick, gate, retrigger;
   logic [23:0] attack_base, attack_coef, decay_coef, sustain_level, release_coef;
   logic [23:0] envelope;
   logic [2:0]  env_state;
   logic        idle;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        gate;
      logic [23:0] exp_env;
      logic [2:0]  exp_state;
      logic        exp_idle;
   } vec_t;

   vec_t rel_tbl[17];

   adsr_env_gen dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sample_tick   (sample_tick),
      .gate          (gate),
      .retrigger     (retrigger),
      .attack_base   (attack_base),
      .attack_coef   (attack_coef),
      .decay_coef    (decay_coef),
      .sustain_level (sustain_level),
      .release_coef  (release_coef),
      .envelope      (envelope),
      .env_state     (env_state),
      .idle          (idle)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time %0t exceeded, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic do_tick();
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
   endtask

   task automatic check_out(input string name, input logic [23:0] e, input env_state_t s);
      check({name, ".env"}, 32'(envelope), 32'(e));
      check({name, ".state"}, 32'(env_state), 32'(s));
   endtask

   initial begin
      int n;
      logic [23:0] hold_env;
      logic [2:0]  hold_st;
      logic        stable;

      // Release from 0x800000 with coef 0.5: hold, then 15 halvings to 0x100, then IDLE.
      rel_tbl[0] = '{1'b0, 24'h800000, 3'(RELEASE), 1'b0};
      for (int k = 1; k <= 15; k++)
         rel_tbl[k] = '{1'b0, 24'h800000 >> k, 3'(RELEASE), 1'b0};
      rel_tbl[16] = '{1'b0, 24'h000000, 3'(IDLE), 1'b1};

      rst_n = 1'b0; sample_tick = 1'b0; gate = 1'b0; retrigger = 1'b0;
      attack_base = '0; attack_coef = '0; decay_coef = '0;
      sustain_level = '0; release_coef = '0;
      repeat (3) @(negedge clk);
      check_out("reset", 24'h0, IDLE);
      check("reset.idle", 32'(idle), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      check_out("post_reset", 24'h0, IDLE);
      do_tick();
      check_out("idle_gate_low", 24'h0, IDLE);

      // Attack ramp
      attack_base = 24'd391; attack_coef = 24'd16776829; gate = 1'b1;
      do_tick(); check_out("atk_t1", 24'd0, ATTACK);
      check("atk_t1.idle", 32'(idle), 32'd0);
      do_tick(); check_out("atk_t2", 24'd391, ATTACK);
      do_tick(); check_out("atk_t3", 24'd781, ATTACK);
      attack_base = 24'h800000; attack_coef = 24'h800000;
      do_tick(); check_out("atk_t4", 24'h800186, ATTACK);
      for (int i = 0; i < 40 && env_state != 3'(DECAY); i++) do_tick();
      check_out("atk_sat", ENV_MAX, DECAY);

      // Decay toward sustain
      sustain_level = 24'h800000; decay_coef = 24'h800000;
      do_tick(); check_out("dec_t1", 24'hBFFFFF, DECAY);
      do_tick(); check_out("dec_t2", 24'h9FFFFF, DECAY);
      n = 2;
      while (env_state != 3'(SUSTAIN) && n < 40) begin
         do_tick();
         n++;
      end
      check("dec_ticks", 32'(n), 32'd15);
      check_out("dec_end", 24'h800000, SUSTAIN);
      sustain_level = 24'h400000;
      do_tick(); check_out("sus_track", 24'h400000, SUSTAIN);
      sustain_level = 24'h800000;
      do_tick(); check_out("sus_back", 24'h800000, SUSTAIN);

      // Release sweep
      release_coef = 24'h800000;
      for (int k = 0; k < 17; k++) begin
         gate = rel_tbl[k].gate;
         do_tick();
         check($sformatf("rel[%0d].env", k), 32'(envelope), 32'(rel_tbl[k].exp_env));
         check($sformatf("rel[%0d].state", k), 32'(env_state), 32'(rel_tbl[k].exp_state));
         check($sformatf("rel[%0d].idle", k), 32'(idle), 32'(rel_tbl[k].exp_idle));
      end

      // Legato: attack restarts from the released level
      attack_base = 24'h200000; attack_coef = 24'h0; gate = 1'b1;
      do_tick(); check_out("leg_atk0", 24'h0, ATTACK);
      do_tick(); check_out("leg_atk1", 24'h200000, ATTACK);
      gate = 1'b0;
      do_tick(); check_out("leg_rel", 24'h200000, RELEASE);
      gate = 1'b1; attack_base = 24'd391; attack_coef = 24'd16776829;
      do_tick(); check_out("leg_hold", 24'h200000, ATTACK);
      do_tick(); check_out("leg_step", 24'd2097494, ATTACK);

      // Retrigger from SUSTAIN, then no ticks for 100 clocks
      attack_base = ENV_MAX; sustain_level = 24'h300000; decay_coef = 24'h0;
      do_tick(); check_out("rt_sat", ENV_MAX, DECAY);
      do_tick(); check_out("rt_sus", 24'h300000, SUSTAIN);
      @(negedge clk); retrigger = 1'b1;
      @(negedge clk); retrigger = 1'b0;
      @(negedge clk);
      check_out("rt_wait", 24'h300000, SUSTAIN);
      do_tick(); check_out("rt_hit", 24'h300000, ATTACK);
      hold_env = envelope; hold_st = env_state; stable = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (envelope !== hold_env || env_state !== hold_st) stable = 1'b0;
      end
      check("no_tick_stable", 32'(stable), 32'd1);
      check_out("no_tick_end", 24'h300000, ATTACK);
      do_tick(); check_out("rt_cleared", ENV_MAX, DECAY);

      // Asynchronous reset mid-decay
      sustain_level = 24'h800000; decay_coef = 24'h800000;
      do_tick(); check_out("ar_dec", 24'hBFFFFF, DECAY);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_out("ar_now", 24'h0, IDLE);
      check("ar_now.idle", 32'(idle), 32'd1);
      @(negedge clk); rst_n = 1'b1;
      do_tick(); check_out("ar_restart", 24'h0, ATTACK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/adsr_env_gen.md
Name: adsr_env_gen

Overview:
- Full per-voice ADSR envelope generator with exponential segments.
- Attack uses the rising recurrence env = base + env*coef/2^24.
- Decay and release use the falling recurrence, which decays the envelope toward a target.
- Sits between the MIDI note/gate logic and the per-voice VCA multiplier; advances one step per audio sample strobe.

Parameters:
- BIT_DEPTH, 24, width of envelope, coefficients and levels (unsigned Q0.24).
- END_THRESH, 256, decay/release snap threshold in LSBs.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_tick  in  1  one-clk strobe; envelope advances only on this
- gate  in  1  note held (level)
- retrigger  in  1  one-clk pulse; restart attack while gate held
- attack_base  in  BIT_DEPTH  attack additive term
- attack_coef  in  BIT_DEPTH  attack multiplier
- decay_coef  in  BIT_DEPTH  decay multiplier
- sustain_level  in  BIT_DEPTH  sustain target
- release_coef  in  BIT_DEPTH  release multiplier
- envelope  out  BIT_DEPTH  current envelope
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- idle  out  1  high when env_state==IDLE

Behaviour:
- Reset (async, rst_n low): envelope=0, env_state=IDLE, idle=1, retrigger latch cleared. Outputs hold these values until the first tick after release of reset.
- Retrigger latch: a retrigger pulse sets a latch. The latch clears on the next sample_tick. Pulse and tick in the same clk: the latch is consumed by that tick.
- All state/envelope updates happen on the clk edge where sample_tick=1. Registered outputs change 1 clk after the tick; otherwise they hold.
- Gate transition tick: if the tick causes a gate-driven state change, the envelope holds its value on that tick. The new segment's recurrence starts on the following tick.
- Gate rules evaluated at each tick, in priority order:
  - gate=0 in ATTACK/DECAY/SUSTAIN -> RELEASE.
  - gate=1 in IDLE/RELEASE -> ATTACK. Legato: attack starts from the current envelope, not from 0.
  - gate=1, latch set, in DECAY/SUSTAIN/ATTACK -> ATTACK, envelope held.
- ATTACK:
  - n = attack_base + (env*attack_coef)[47:24], computed 25 bits wide.
  - If n >= 2^24-1 (carry included): envelope=2^24-1, -> DECAY. Else envelope=n.
- DECAY:
  - If env <= sustain_level: envelope=sustain_level, -> SUSTAIN.
  - Else d = env - sustain_level; m = (d*decay_coef)[47:24].
  - If m < END_THRESH: envelope=sustain_level, -> SUSTAIN. Else envelope = sustain_level + m.
- SUSTAIN: envelope = sustain_level each tick, so live changes are tracked.
- RELEASE:
  - m = (env*release_coef)[47:24].
  - If m < END_THRESH: envelope=0, -> IDLE. Else envelope=m.
- IDLE: envelope=0.
- Arithmetic: full 48-bit unsigned products, truncated (floor). No rounding. Coefficients are sampled at the tick.
- Reset mid-segment: immediate return to IDLE/0 regardless of gate. After reset, gate=1 at the first tick -> ATTACK.

Decomposition:
- Shared package adsr_pkg: env_state_t enum (IDLE..RELEASE, 3-bit), BIT_DEPTH default, ENV_MAX = 24'hFFFFFF.
- One sub-module: env_mul, a combinational BIT_DEPTH x BIT_DEPTH unsigned multiplier returning the upper BIT_DEPTH bits. It is shared by all segments, since only one segment is active per tick; it can be pipelined later if timing needs it.

Test Plan:
- Attack ramp: reset, attack_base=391, attack_coef=16776829, gate=1. Tick1 -> ATTACK, env 0 (gate-transition hold). Tick2 -> env=391. Tick3 -> env=781. Run to saturation: env=0xFFFFFF, env_state=DECAY.
- Decay: from env=0xFFFFFF in DECAY with sustain_level=0x800000, decay_coef=0x800000. Next tick -> 0xBFFFFF, then 0x9FFFFF. Converges to exactly 0x800000, env_state=SUSTAIN. Changing sustain_level to 0x400000 -> env=0x400000 on the next tick.
- Release: env=0x800000 in SUSTAIN, release_coef=0x800000, drop gate. Tick1 -> RELEASE, env held. Next 15 ticks halve to 0x000100. Following tick -> env=0, IDLE, idle=1.
- Legato: in RELEASE at env=0x200000, raise gate. Tick -> ATTACK with env 0x200000 held. Next tick = attack_base + (0x200000*attack_coef)>>24.
- Retrigger plus gating of updates: in SUSTAIN, pulse retrigger 3 clks before a tick. No change until the tick; then ATTACK, env held. No sample_tick for 100 clks -> outputs constant.
- Async reset: assert rst_n=0 mid-DECAY between clk edges -> envelope=0, env_state=IDLE immediately, without waiting for a clk edge.
